seg_serializer: RTL and testbench
=================================

Name: seg_serializer

Overview:
- Downstream stage of the hex-to-segment decoder.
- Takes the 64-bit segment pattern (8 digits x 8 bits), captures it on a start request and shifts it out bit-serially to the board's external 74HC164-style shift-register chain (s_clk, s_clrn, sout).
- Drives the display output-enable EN low while a frame is in flight and high once the frame is complete.
- Sits between the segment decoder and the board pins of the 7-segment display.

Parameters:
- DATA_BITS, 64, number of bits per frame.
- CNT_BITS, 6, bit-counter width; must satisfy 2^CNT_BITS >= DATA_BITS.
- DIR, 0, shift order: 0 = pdata[DATA_BITS-1] first (MSB first), 1 = pdata[0] first.
- CLK_DIV, 1, system clocks per half-period of s_clk; legal values >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame request, level signal; only its rising edge is acted on.
- pdata  input  DATA_BITS  segment pattern; sampled only in the edge-detect cycle.
- s_clk  output  1  serial clock to the external shifter; data is taken on its rising edge.
- s_clrn  output  1  active-low clear of the external shifter.
- sout  output  1  serial data.
- EN  output  1  display output-enable; 0 while shifting, 1 when the frame is stable.
- busy  output  1  frame in progress.

Behaviour:
- Reset values, all registered: s_clk=0, s_clrn=0, sout=0, EN=0, busy=0, state=IDLE, bit counter=0, divider=0, start_q=0.
- s_clrn goes to 1 in the first cycle after rst deasserts and stays 1 until the next reset.
- Edge detect: start_q <= start; a request is start & ~start_q.
- Requests are honoured only in IDLE. A request seen while busy=1 is dropped, not queued.
- Tick: the divider counts 0..CLK_DIV-1 and produces a one-cycle tick at CLK_DIV-1. The divider is held at 0 in IDLE. With CLK_DIV=1, tick is high every cycle.
- States: IDLE, SHIFT_LO, SHIFT_HI.
- IDLE, request seen in cycle N:
  - shift register <= pdata, counter <= 0, busy <= 1, EN <= 0, s_clk <= 0.
  - sout <= first bit of the frame.
  - state <= SHIFT_LO.
  - All of these are visible in cycle N+1.
- SHIFT_LO, on tick: s_clk <= 1, state <= SHIFT_HI. sout is unchanged, giving a full half-period of setup.
- SHIFT_HI, on tick: s_clk <= 0.
  - If counter == DATA_BITS-1: state <= IDLE, busy <= 0, EN <= 1, sout <= 0.
  - Otherwise: shift the register toward the output end (DIR selects the direction), sout <= next bit, counter <= counter+1, state <= SHIFT_LO.
- Latency with CLK_DIV=1 and request in cycle N:
  - s_clk rising edges in cycles N+2+2k for k = 0..DATA_BITS-1.
  - Final fall of s_clk, EN=1 and busy=0 together in cycle N+1+2*DATA_BITS, i.e. N+129 for 64 bits.
- General frame length: 2*CLK_DIV*DATA_BITS cycles from the first SHIFT_LO cycle to the IDLE cycle.
- EN stays 1 after a frame until the next request; it drops to 0 in the cycle after that request's detect cycle.
- Counter width: CNT_BITS bits; the terminal compare is against DATA_BITS-1, never against counter wrap.
- Reset mid-frame: the next cycle shows every output at its reset value. The partial frame is abandoned and nothing resumes afterwards.
- start held high continuously produces exactly one frame. A new frame requires start to go low and then high again.
- Request in the same cycle as the frame's final SHIFT_HI tick: state is not yet IDLE, so the request is dropped.

Decomposition:
- Shared defines header (the existing defines include) gets the state encodings SEG_S_IDLE, SEG_S_LO and SEG_S_HI, plus the default SEG_FRAME_BITS = 64.
- One sub-module, seg_tick_gen: parameter CLK_DIV; inputs clk, rst, run; output tick.
- The FSM, shift register and counter stay in seg_serializer.

Test Plan:
1. Reset release: rst high for 3 cycles, then low → s_clrn=0 during reset and 1 on the first cycle after; s_clk=sout=EN=busy=0.
2. MSB-first frame, DIR=0, CLK_DIV=1, pdata=64'h8000_0000_0000_0001, start rising in cycle N:
   - sout=1 at the first s_clk rise (N+2).
   - sout=0 for the next 62 rises.
   - sout=1 at the 64th rise (N+128).
   - EN=1 and busy=0 at N+129; exactly 64 s_clk rising edges counted.
3. DIR=1 with pdata=64'h0000_0000_0000_00A5: sequence at the rises is 1,0,1,0,0,1,0,1 followed by 56 zeros. Monitor reconstructs the value 64'hA5.
4. CLK_DIV=4: s_clk high and low phases are each exactly 4 cycles; the frame takes 512 cycles; the captured word equals pdata.
5. Second start edge at rise #10 with pdata changed to all-ones: ignored. Frame completes with the original data and busy shows no glitch. A new edge after busy=0 produces the all-ones frame.
6. rst asserted at rise #30: all outputs at reset values the next cycle. A later start edge produces a complete, correct 64-bit frame.

Source files
------------

// File: rtl/seg_serializer_pkg.sv
// Shared constants for the segment serializer: FSM encodings, default frame size
// and a helper that sizes the clock divider.
package seg_serializer_pkg;

  localparam int SEG_FRAME_BITS = 64;

  localparam logic [1:0] SEG_S_IDLE = 2'd0;
  localparam logic [1:0] SEG_S_LO   = 2'd1;
  localparam logic [1:0] SEG_S_HI   = 2'd2;

  // A divide-by-1 still needs a one-bit counter so the port widths stay legal.
  function automatic int seg_div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Half-period tick for the serial clock: one-cycle pulse every CLK_DIV cycles while run=1.
// The divider is held at 0 when run=0, so the first tick lands CLK_DIV cycles after run rises.
module seg_tick_gen
  import seg_serializer_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int            DW   = seg_div_width(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  assign tick = run && (div_q == LAST);

  always_comb begin
    div_d = div_q;
    if (!run || tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/seg_serializer.sv
// Captures a segment frame on a rising start and shifts it out to a 74HC164-style chain;
// 2*CLK_DIV cycles per bit, no backpressure: requests arriving while busy are dropped.
module seg_serializer
  import seg_serializer_pkg::*;
#(
  parameter int DATA_BITS = SEG_FRAME_BITS,
  parameter int CNT_BITS  = 6,
  parameter int DIR       = 0,
  parameter int CLK_DIV   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] pdata,
  output logic                 s_clk,
  output logic                 s_clrn,
  output logic                 sout,
  output logic                 EN,
  output logic                 busy
);

  localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(DATA_BITS - 1);

  logic [1:0]           state_q, state_d;
  logic [DATA_BITS-1:0] sreg_q, sreg_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 s_clk_q, s_clk_d;
  logic                 s_clrn_q;
  logic                 sout_q, sout_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 start_q;
  logic                 req;
  logic                 tick;

  assign req = start & ~start_q;

  seg_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (state_q != SEG_S_IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    s_clk_d = s_clk_q;
    sout_d  = sout_q;
    en_d    = en_q;
    busy_d  = busy_q;
    case (state_q)
      SEG_S_IDLE: begin
        if (req) begin
          sreg_d  = pdata;
          cnt_d   = '0;
          busy_d  = 1'b1;
          en_d    = 1'b0;
          s_clk_d = 1'b0;
          sout_d  = (DIR == 0) ? pdata[DATA_BITS-1] : pdata[0];
          state_d = SEG_S_LO;
        end
      end
      SEG_S_LO: begin
        // sout was set on the previous falling edge; it stays put for a full half-period of setup.
        if (tick) begin
          s_clk_d = 1'b1;
          state_d = SEG_S_HI;
        end
      end
      SEG_S_HI: begin
        if (tick) begin
          s_clk_d = 1'b0;
          if (cnt_q == LAST_BIT) begin
            state_d = SEG_S_IDLE;
            busy_d  = 1'b0;
            en_d    = 1'b1;
            sout_d  = 1'b0;
          end else begin
            if (DIR == 0) begin
              sreg_d = {sreg_q[DATA_BITS-2:0], 1'b0};
              sout_d = sreg_q[DATA_BITS-2];
            end else begin
              sreg_d = {1'b0, sreg_q[DATA_BITS-1:1]};
              sout_d = sreg_q[1];
            end
            cnt_d   = cnt_q + CNT_BITS'(1);
            state_d = SEG_S_LO;
          end
        end
      end
      default: state_d = SEG_S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEG_S_IDLE;
      sreg_q   <= '0;
      cnt_q    <= '0;
      s_clk_q  <= 1'b0;
      s_clrn_q <= 1'b0;
      sout_q   <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      s_clk_q  <= s_clk_d;
      s_clrn_q <= 1'b1;
      sout_q   <= sout_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      start_q  <= start;
    end
  end

  assign s_clk  = s_clk_q;
  assign s_clrn = s_clrn_q;
  assign sout   = sout_q;
  assign EN     = en_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_seg_serializer.sv
// Bench for seg_serializer: three instances (MSB-first, LSB-first, divide-by-4) with a
// scoreboard monitor rebuilding each shifted frame from the s_clk rising edges.
module tb_seg_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = 3'b000;
  logic [63:0] pd [3];

  wire [2:0] sclk_v, clrn_v, sout_v, en_v, busy_v;

  int checks = 0;
  int errors = 0;

  logic [63:0] expq0[$];
  logic [63:0] expq1[$];
  logic [63:0] expq2[$];

  always #5 clk = ~clk;

  seg_serializer #(.DATA_BITS(64), .CNT_BITS(6), .DIR(0), .CLK_DIV(1)) u_msb (
    .clk(clk), .rst(rst), .start(start_v[0]), .pdata(pd[0]),
    .s_clk(sclk_v[0]), .s_clrn(clrn_v[0]), .sout(sout_v[0]), .EN(en_v[0]), .busy(busy_v[0]));

  seg_serializer #(.DATA_BITS(64), .CNT_BITS(6), .DIR(1), .CLK_DIV(1)) u_lsb (
    .clk(clk), .rst(rst), .start(start_v[1]), .pdata(pd[1]),
    .s_clk(sclk_v[1]), .s_clrn(clrn_v[1]), .sout(sout_v[1]), .EN(en_v[1]), .busy(busy_v[1]));

  seg_serializer #(.DATA_BITS(64), .CNT_BITS(6), .DIR(0), .CLK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .start(start_v[2]), .pdata(pd[2]),
    .s_clk(sclk_v[2]), .s_clrn(clrn_v[2]), .sout(sout_v[2]), .EN(en_v[2]), .busy(busy_v[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [63:0] d);
    case (i)
      0:       expq0.push_back(d);
      1:       expq1.push_back(d);
      default: expq2.push_back(d);
    endcase
  endtask

  // Monitor: rebuilds the word from sout at each s_clk rise, scores it when busy falls.
  logic [63:0] mword [3];
  int          mbits [3];
  logic        mp_sclk [3];
  logic        mp_busy [3];

  task automatic frame_done(input int i);
    logic [63:0] e;
    bit          have;
    have = 1'b0;
    e    = '0;
    case (i)
      0:       if (expq0.size() > 0) begin e = expq0.pop_front(); have = 1'b1; end
      1:       if (expq1.size() > 0) begin e = expq1.pop_front(); have = 1'b1; end
      default: if (expq2.size() > 0) begin e = expq2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame%0d: got word %h with no frame requested", i, mword[i]);
    end else begin
      check($sformatf("frame_word%0d", i), mword[i], e);
      check($sformatf("frame_bits%0d", i), 64'(mbits[i]), 64'd64);
      check($sformatf("frame_en%0d", i), 64'(en_v[i]), 64'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      mword[i] = '0; mbits[i] = 0; mp_sclk[i] = 1'b0; mp_busy[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          mword[i] = '0; mbits[i] = 0; mp_sclk[i] = 1'b0; mp_busy[i] = 1'b0;
        end else begin
          if (busy_v[i] && !mp_busy[i]) begin
            mword[i] = '0;
            mbits[i] = 0;
          end
          if (sclk_v[i] && !mp_sclk[i]) begin
            mbits[i]++;
            if (i == 1) mword[i] = {sout_v[i], mword[i][63:1]};
            else        mword[i] = {mword[i][62:0], sout_v[i]};
          end
          if (!busy_v[i] && mp_busy[i]) frame_done(i);
          mp_sclk[i] = sclk_v[i];
          mp_busy[i] = busy_v[i];
        end
      end
      if (rst) begin
        expq0.delete(); expq1.delete(); expq2.delete();
      end
    end
  end

  // Issues one frame on instance i and follows it cycle by cycle (k = cycles after detect).
  // act_kind: 0 none, 1 new all-ones edge at rise act_k, 2 reset at rise act_k, 3 edge at cycle act_k.
  task automatic run_frame(input int i, input logic [63:0] d, input int div,
                           input int act_k, input int act_kind,
                           output int rises, output int done_k, output int bad_phase,
                           output logic [7:0] first8);
    int   frame_len;
    logic prev;
    logic exp_s;
    frame_len = 2 * div * 64;
    rises = 0; done_k = -1; bad_phase = 0; first8 = '0; prev = 1'b0;
    @(negedge clk);
    pd[i] = d;
    start_v[i] = 1'b1;
    push_exp(i, d);
    for (int k = 1; k <= frame_len + 20; k++) begin
      @(negedge clk);
      if (k == 1) check($sformatf("busy_en_after_detect%0d", i), 64'({busy_v[i], en_v[i]}), 64'b10);
      if (k == 2) start_v[i] = 1'b0;
      exp_s = (k <= frame_len) && ((((k - 1) / div) % 2) == 1);
      if (sclk_v[i] !== exp_s) bad_phase++;
      if (sclk_v[i] && !prev) begin
        rises++;
        if (rises <= 8) first8 = {first8[6:0], sout_v[i]};
        if (act_kind == 1 && rises == act_k) begin
          pd[i] = '1;
          start_v[i] = 1'b1;
        end
        if (act_kind == 2 && rises == act_k) begin
          rst = 1'b1;
          start_v[i] = 1'b0;
          @(negedge clk);
          check("mid_reset_outputs",
                64'({sclk_v[i], clrn_v[i], sout_v[i], en_v[i], busy_v[i]}), 64'd0);
          @(negedge clk);
          rst = 1'b0;
          @(negedge clk);
          check("reset_release_clrn", 64'(clrn_v[i]), 64'd1);
          repeat (4) @(negedge clk);
          check("no_resume_after_reset", 64'({busy_v[i], sclk_v[i]}), 64'd0);
          done_k = -2;
          break;
        end
      end
      prev = sclk_v[i];
      if (act_kind == 3 && k == act_k) begin
        pd[i] = '1;
        start_v[i] = 1'b1;
      end
      if (!busy_v[i]) begin
        done_k = k;
        break;
      end
    end
    if (done_k == -1) $display("FAIL frame_timeout%0d: no completion within %0d cycles", i, frame_len + 20);
    start_v[i] = 1'b0;
  endtask

  initial begin
    int          r, dk, bp;
    logic [7:0]  f8;
    pd[0] = '0; pd[1] = '0; pd[2] = '0;

    // Reset release
    @(negedge clk);
    check("reset_hold_outputs", 64'({sclk_v, clrn_v, sout_v, en_v, busy_v}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_release_clrn_all", 64'(clrn_v), 64'b111);
    check("reset_release_rest", 64'({sclk_v, sout_v, en_v, busy_v}), 64'd0);

    // MSB-first frame
    run_frame(0, 64'h8000_0000_0000_0001, 1, 0, 0, r, dk, bp, f8);
    check("msb_done_cycle", 64'(dk), 64'd129);
    check("msb_rises", 64'(r), 64'd64);
    check("msb_sclk_phase", 64'(bp), 64'd0);
    check("msb_first8", 64'(f8), 64'h80);

    // LSB-first frame
    run_frame(1, 64'h0000_0000_0000_00A5, 1, 0, 0, r, dk, bp, f8);
    check("lsb_done_cycle", 64'(dk), 64'd129);
    check("lsb_rises", 64'(r), 64'd64);
    check("lsb_first8", 64'(f8), 64'hA5);

    // Divide-by-4 frame
    run_frame(2, 64'h0123_4567_89AB_CDEF, 4, 0, 0, r, dk, bp, f8);
    check("div4_done_cycle", 64'(dk), 64'd513);
    check("div4_rises", 64'(r), 64'd64);
    check("div4_sclk_phase", 64'(bp), 64'd0);

    // Edge while busy is dropped; a fresh edge afterwards is honoured
    run_frame(0, 64'hDEAD_BEEF_0F0F_5AA5, 1, 10, 1, r, dk, bp, f8);
    check("busy_edge_done_cycle", 64'(dk), 64'd129);
    check("busy_edge_phase", 64'(bp), 64'd0);
    repeat (3) @(negedge clk);
    check("busy_edge_not_queued", 64'(busy_v[0]), 64'd0);
    run_frame(0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, r, dk, bp, f8);
    check("ones_done_cycle", 64'(dk), 64'd129);

    // Reset mid-frame, then a clean frame
    run_frame(0, 64'h1357_9BDF_2468_ACE0, 1, 30, 2, r, dk, bp, f8);
    check("mid_reset_aborted", 64'(dk), 64'hFFFF_FFFF_FFFF_FFFE);
    run_frame(0, 64'hFEDC_BA98_7654_3210, 1, 0, 0, r, dk, bp, f8);
    check("post_reset_done_cycle", 64'(dk), 64'd129);
    check("post_reset_rises", 64'(r), 64'd64);

    // Edge landing on the final SHIFT_HI tick is dropped
    run_frame(0, 64'h0000_0000_FFFF_0000, 1, 128, 3, r, dk, bp, f8);
    check("last_tick_done_cycle", 64'(dk), 64'd129);
    repeat (4) @(negedge clk);
    check("last_tick_edge_dropped", 64'({busy_v[0], en_v[0]}), 64'b01);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(expq0.size() + expq1.size() + expq2.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
